// File: rtl/interrupt_spr_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_spr_unit_if
//  Description : Cause/context inputs, SPR access and interrupt status outputs
//                of the interrupt/SPR unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_spr_unit_if;
  logic [22:0] ca;
  logic        rpt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] ea;
  logic [31:0] data_in;
  logic [2:0]  reg_sel;
  logic        sprw;
  logic [31:0] spr_out;
  logic [31:0] sr;
  logic [22:0] mca;
  logic        jisr;
  logic [31:0] il;
  logic [31:0] mode;

  modport master (
    output ca, rpt, pc, next_pc, ea, data_in, reg_sel, sprw,
    input  spr_out, sr, mca, jisr, il, mode
  );

  modport slave (
    input  ca, rpt, pc, next_pc, ea, data_in, reg_sel, sprw,
    output spr_out, sr, mca, jisr, il, mode
  );
endinterface
`default_nettype wire

// File: rtl/interrupt_spr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_spr_unit
//  Description : Interrupt cause masking/priority plus the 8-entry SPR file
//                that captures interrupt context on jisr.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_spr_unit (
  input  wire logic             clk,
  input  wire logic             rst,
  interrupt_spr_unit_if.slave   bus
);

  localparam logic [2:0]  c_SEL_SR    = 3'd0;
  localparam logic [2:0]  c_SEL_ESR   = 3'd1;
  localparam logic [2:0]  c_SEL_ECA   = 3'd2;
  localparam logic [2:0]  c_SEL_EPC   = 3'd3;
  localparam logic [2:0]  c_SEL_EDATA = 3'd4;
  localparam logic [2:0]  c_SEL_EMODE = 3'd5;
  localparam logic [2:0]  c_SEL_MODE  = 3'd7;
  // ovf and the 16 external lines can be masked; internal faults cannot
  localparam logic [22:0] c_MASKABLE  = 23'h7F_FF81;

  logic [31:0] r_sr;
  logic [31:0] r_esr;
  logic [22:0] r_eca;
  logic [31:0] r_epc;
  logic [31:0] r_edata;
  logic [31:0] r_emode;
  logic [31:0] r_mode;

  logic [22:0] w_mca;
  logic        w_jisr;
  logic [4:0]  w_il;
  logic [31:0] w_spr_out;

  assign w_mca  = bus.ca & (r_sr[22:0] | ~c_MASKABLE);
  assign w_jisr = |w_mca;

  // Scan from the top so the lowest set index is the final assignment
  always_comb begin
    w_il = 5'd0;
    for (int j = 22; j >= 0; j--) begin
      if (w_mca[j]) begin
        w_il = 5'(j);
      end
    end
  end

  always_comb begin
    w_spr_out = 32'd0;
    case (bus.reg_sel)
      c_SEL_SR:    w_spr_out = r_sr;
      c_SEL_ESR:   w_spr_out = r_esr;
      c_SEL_ECA:   w_spr_out = {9'd0, r_eca};
      c_SEL_EPC:   w_spr_out = r_epc;
      c_SEL_EDATA: w_spr_out = r_edata;
      c_SEL_EMODE: w_spr_out = r_emode;
      c_SEL_MODE:  w_spr_out = r_mode;
      default:     w_spr_out = 32'd0;
    endcase
  end

  // Context save outranks software writes in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= 32'd0;
      r_esr   <= 32'd0;
      r_eca   <= 23'd0;
      r_epc   <= 32'd0;
      r_edata <= 32'd0;
      r_emode <= 32'd0;
      r_mode  <= 32'd0;
    end else if (w_jisr) begin
      r_esr   <= r_sr;
      r_sr    <= 32'd0;
      r_eca   <= w_mca;
      r_epc   <= bus.rpt ? bus.pc : bus.next_pc;
      r_edata <= bus.ea;
      r_emode <= r_mode;
      r_mode  <= 32'd0;
    end else if (bus.sprw) begin
      case (bus.reg_sel)
        c_SEL_SR:    r_sr    <= bus.data_in;
        c_SEL_ESR:   r_esr   <= bus.data_in;
        c_SEL_ECA:   r_eca   <= bus.data_in[22:0];
        c_SEL_EPC:   r_epc   <= bus.data_in;
        c_SEL_EDATA: r_edata <= bus.data_in;
        c_SEL_EMODE: r_emode <= bus.data_in;
        c_SEL_MODE:  r_mode  <= bus.data_in;
        default:     ;
      endcase
    end
  end

  assign bus.spr_out = w_spr_out;
  assign bus.sr      = r_sr;
  assign bus.mca     = w_mca;
  assign bus.jisr    = w_jisr;
  assign bus.il      = {27'd0, w_il};
  assign bus.mode    = r_mode;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_spr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_spr_unit
//  Description : Directed self-checking bench for interrupt_spr_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_spr_unit;

  localparam int c_K_SPR  = 0;
  localparam int c_K_SR   = 1;
  localparam int c_K_MCA  = 2;
  localparam int c_K_JISR = 3;
  localparam int c_K_IL   = 4;
  localparam int c_K_MODE = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  interrupt_spr_unit_if intf ();

  interrupt_spr_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int kind);
    case (kind)
      c_K_SPR:  return intf.spr_out;
      c_K_SR:   return intf.sr;
      c_K_MCA:  return {9'd0, intf.mca};
      c_K_JISR: return {31'd0, intf.jisr};
      c_K_IL:   return intf.il;
      default:  return intf.mode;
    endcase
  endfunction

  // Reference: maskable = bit 0 and bits 7..22
  function automatic logic [22:0] model_mca(logic [22:0] ca, logic [31:0] sr);
    logic [22:0] m;
    for (int j = 0; j < 23; j++) begin
      if (j == 0 || j >= 7) m[j] = ca[j] & sr[j];
      else                  m[j] = ca[j];
    end
    return m;
  endfunction

  function automatic logic [31:0] model_il(logic [22:0] m);
    for (int j = 0; j < 23; j++) begin
      if (m[j]) return 32'(j);
    end
    return 32'd0;
  endfunction

  task automatic push(string tag, int kind, logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_write(logic [2:0] sel, logic [31:0] data);
    intf.reg_sel = sel;
    intf.data_in = data;
    intf.sprw    = 1'b1;
    step();
    intf.sprw    = 1'b0;
  endtask

  task automatic check_spr(string tag, logic [2:0] sel, logic [31:0] exp);
    intf.reg_sel = sel;
    #1;
    push(tag, c_K_SPR, exp);
    drain();
  endtask

  task automatic check_cause(string tag, logic [22:0] ca, logic [31:0] sr);
    logic [22:0] m;
    intf.ca = ca;
    #1;
    m = model_mca(ca, sr);
    push({tag, "_mca"},  c_K_MCA,  {9'd0, m});
    push({tag, "_jisr"}, c_K_JISR, {31'd0, |m});
    push({tag, "_il"},   c_K_IL,   model_il(m));
    drain();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    intf.ca      = '0;
    intf.rpt     = 1'b0;
    intf.pc      = '0;
    intf.next_pc = '0;
    intf.ea      = '0;
    intf.data_in = '0;
    intf.reg_sel = '0;
    intf.sprw    = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset from a nonzero SR
    spr_write(3'd0, 32'h0000_0055);
    push("sr_pre_reset", c_K_SR, 32'h0000_0055);
    drain();
    spr_write(3'd7, 32'h0000_0001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    push("reset_sr",   c_K_SR,   32'd0);
    push("reset_mode", c_K_MODE, 32'd0);
    push("reset_jisr", c_K_JISR, 32'd0);
    drain();
    for (int i = 0; i < 8; i++) check_spr($sformatf("reset_spr%0d", i), 3'(i), 32'd0);

    // Masking of ovf
    check_cause("ovf_masked", 23'h000001, 32'd0);
    intf.ca = '0;
    spr_write(3'd0, 32'h0000_0001);
    check_cause("ovf_enabled", 23'h000001, 32'h1);
    intf.ca = '0;
    spr_write(3'd0, 32'h0000_0000);

    // Non-maskable causes with priority
    check_cause("nonmask", 23'h000052, 32'd0);
    check_cause("ext_masked", 23'h400080, 32'd0);
    intf.ca = '0;

    // Context save, repeat type
    spr_write(3'd0, 32'hFFFF_FFFF);
    spr_write(3'd7, 32'h0000_0001);
    check_cause("ext_low", 23'h400080, 32'hFFFF_FFFF);
    check_cause("ext_top", 23'h400000, 32'hFFFF_FFFF);
    intf.pc      = 32'h100;
    intf.next_pc = 32'h104;
    intf.ea      = 32'h203;
    intf.rpt     = 1'b1;
    check_cause("misals", 23'h000008, 32'hFFFF_FFFF);
    step();
    intf.ca = '0;
    push("save_sr",   c_K_SR,   32'd0);
    push("save_mode", c_K_MODE, 32'd0);
    drain();
    check_spr("save_esr",   3'd1, 32'hFFFF_FFFF);
    check_spr("save_eca",   3'd2, 32'h8);
    check_spr("save_epc",   3'd3, 32'h100);
    check_spr("save_edata", 3'd4, 32'h203);
    check_spr("save_emode", 3'd5, 32'h1);

    // Continue type
    intf.rpt = 1'b0;
    intf.ca  = 23'h000008;
    step();
    intf.ca = '0;
    check_spr("cont_epc",   3'd3, 32'h104);
    check_spr("cont_esr",   3'd1, 32'd0);
    check_spr("cont_emode", 3'd5, 32'd0);

    // Write and read back every SPR
    for (int i = 0; i < 8; i++) spr_write(3'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      logic [31:0] pat;
      pat = 32'hA5A5_0000 + 32'(i);
      if (i == 2)      pat = pat & 32'h007F_FFFF;
      else if (i == 6) pat = 32'd0;
      check_spr($sformatf("rw_spr%0d", i), 3'(i), pat);
    end

    // sprw to EPC lost against a simultaneous jisr
    intf.pc      = 32'h300;
    intf.next_pc = 32'h304;
    intf.rpt     = 1'b1;
    intf.ca      = 23'h000002;
    spr_write(3'd3, 32'h0000_DEAD);
    intf.ca = '0;
    check_spr("collide_epc", 3'd3, 32'h300);
    check_spr("collide_eca", 3'd2, 32'h2);

    // Reset together with jisr
    spr_write(3'd0, 32'h1234_5678);
    spr_write(3'd7, 32'h1);
    intf.ca = 23'h000002;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
    intf.ca = '0;
    for (int i = 0; i < 8; i++) check_spr($sformatf("rstjisr_spr%0d", i), 3'(i), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_spr_unit.md
Name: interrupt_spr_unit

Overview:
Combined interrupt controller and special-purpose register (SPR) file for the MIPS-style CPU.
- The combinational part masks the 23-bit interrupt cause vector with the status register and raises jisr (jump to interrupt service routine). It also reports the interrupt level.
- The sequential part holds 8 SPRs. On jisr it saves the interrupt context; otherwise it takes move-to-SPR writes.
- Sits beside the datapath. The surrounding interrupt wrapper builds the cause vector.

Parameters:
None (widths fixed: 32-bit data, 23 cause bits, 3-bit SPR select).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
ca  input  23  cause vector. Bit 0 ovf, 1 sysc, 2 pfls, 3 misals, 4 ill, 5 pff, 6 misaf, 22..7 external
rpt  input  1  1 = interrupt is of repeat type (EPC saves pc); 0 = continue type (EPC saves next_pc)
pc  input  32  address of the current instruction
next_pc  input  32  address of the following instruction
ea  input  32  effective address of the current load/store
data_in  input  32  write data for SPR write
reg_sel  input  3  SPR index for read and write
sprw  input  1  SPR write enable
spr_out  output  32  SPR[reg_sel], combinational read
sr  output  32  current status register (interrupt mask)
mca  output  23  masked cause vector
jisr  output  1  1 when any mca bit is set
il  output  32  interrupt level, zero-extended
mode  output  32  current mode register; 0 = system, 1 = user

Behaviour:
- SPR map:
  - 0 SR
  - 1 ESR
  - 2 ECA (23 bits, zero-extended on read)
  - 3 EPC
  - 4 EDATA
  - 5 EMODE
  - 6 reserved: reads 0, writes ignored
  - 7 MODE
- Maskable causes: bit 0 (ovf) and bits 7..22 (external).
  - For maskable bit j: mca[j] = ca[j] & sr[j].
  - All other bits: mca[j] = ca[j] (non-maskable).
- jisr = OR of mca[22:0]; purely combinational, same cycle as ca.
- il = index of the lowest-numbered set bit of mca (lowest index = highest priority). il = 0 when mca is all zero; jisr disambiguates that case.
- Reset (rst=1 at clk edge): all SPRs cleared to 0.
  - sr=0, which masks all maskable causes.
  - mode=0 (system).
  - Reset has priority over jisr and sprw.
- jisr=1 at clk edge (no reset):
  - ESR <= SR
  - SR <= 0
  - ECA <= mca
  - EPC <= rpt ? pc : next_pc
  - EDATA <= ea
  - EMODE <= MODE
  - MODE <= 0
  - An sprw in the same cycle is ignored.
- sprw=1, jisr=0: SPR[reg_sel] <= data_in.
  - ECA keeps data_in[22:0].
  - Writes to index 6 are ignored.
- No jisr, no sprw: all SPRs hold.
- spr_out, sr and mode reflect register contents: a write is visible the cycle after the edge. No bypass.
- Single-cycle latency for all updates. No handshake.

Test Plan:
- Reset with sr previously nonzero: rst=1 for one edge -> sr=0, mode=0, spr_out=0 for every reg_sel, jisr=0 with ca=0.
- Masking:
  - sr=0, ca=23'h000001 (ovf) -> mca=0, jisr=0.
  - Write SR=32'h1 via sprw (reg_sel=0), then same ca -> mca=1, jisr=1, il=0.
- Non-maskable with priority: sr=0, ca=23'h000052 (sysc+ill+misaf) -> mca=23'h000052, jisr=1, il=1.
- Context save on a repeat-type interrupt:
  - Setup: SR=32'hFFFF_FFFF, MODE=1, pc=32'h100, next_pc=32'h104, ea=32'h203, rpt=1, ca=23'h000008.
  - After the edge: ESR=32'hFFFF_FFFF, SR=0, ECA=8, EPC=32'h100, EDATA=32'h203, EMODE=1, mode=0.
  - Repeat with rpt=0 -> EPC=32'h104.
- Write/read all SPRs: write distinct patterns (e.g. 32'hA5A5_0000+i) to indices 0..7 with sprw, ca=0.
  - Read back: index 2 returns pattern & 23'h7FFFFF; index 6 returns 0; others return the exact pattern.
- Simultaneous events:
  - sprw to EPC with data 32'hDEAD while jisr=1 -> EPC holds the saved pc/next_pc, not 32'hDEAD.
  - rst together with jisr -> all SPRs 0.
